// File: rtl/nios_system_switch_pkg.sv
// Shared definitions for the slide-switch debouncer: per-bit FSM encoding,
// default debounce length and the counter width helper.
package nios_system_switch_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return int'($clog2(cycles));
  endfunction

endpackage

// File: rtl/nios_system_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, STABLE/PENDING FSM
// and registered rise/fall event pulses.
module nios_system_debounce_bit
  import nios_system_switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic pending_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;

  // Counter never passes CNT_MAX: reaching it always returns the FSM to STABLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (s2_q != clean_q) begin
            state_q <= PENDING;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        PENDING: begin
          if (s2_q == clean_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            clean_q <= s2_q;
            rise_q  <= s2_q;
            fall_q  <= ~s2_q;
            cnt_q   <= '0;
            state_q <= STABLE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clean_o   = clean_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = (state_q == PENDING);

endmodule

// File: rtl/nios_system_switch_debouncer.sv
// Debounces the raw slide-switch pins into a clean level bus for the switches
// PIO, with per-bit rise/fall event pulses and an aggregate busy flag.
module nios_system_switch_debouncer
  import nios_system_switch_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             busy
);

  logic [WIDTH-1:0] pending;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_system_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_i     (sw_raw[i]),
      .clean_o   (sw_clean[i]),
      .rise_o    (sw_rise[i]),
      .fall_o    (sw_fall[i]),
      .pending_o (pending[i])
    );
  end

  assign busy = |pending;

endmodule

// File: tb/tb_nios_system_switch_debouncer.sv
// Directed bench for the switch debouncer with DEBOUNCE_CYCLES=8, WIDTH=4.
module tb_nios_system_switch_debouncer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  nios_system_switch_debouncer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [3:0] raw,
                     input logic [3:0] clean, input logic [3:0] rise,
                     input logic [3:0] fall, input logic b);
    vec_t v;
    v.rst_n = r;
    v.raw   = raw;
    v.clean = clean;
    v.rise  = rise;
    v.fall  = fall;
    v.busy  = b;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    logic seen_busy;
    logic [3:0] e_clean, e_rise, e_fall;
    logic       e_busy;

    // reset held with all switches high
    reset_n = 1'b0;
    sw_raw  = 4'hF;
    tick();
    tick();
    chk("rst clean", sw_clean, 4'h0);
    chk("rst rise", sw_rise, 4'h0);
    chk("rst fall", sw_fall, 4'h0);
    chk("rst busy", {3'b0, busy}, 4'h0);

    // release: F accepted at edge 10; then all low; then bit0 high
    add(2, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    add(7, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1);
    add(1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0);
    add(1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    add(2, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
    add(7, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add(2, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(7, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    add(1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    add(2, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n = vecs[i].rst_n;
      sw_raw  = vecs[i].raw;
      tick();
      chk($sformatf("vec%0d clean", i), sw_clean, vecs[i].clean);
      chk($sformatf("vec%0d rise", i), sw_rise, vecs[i].rise);
      chk($sformatf("vec%0d fall", i), sw_fall, vecs[i].fall);
      chk($sformatf("vec%0d busy", i), {3'b0, busy}, {3'b0, vecs[i].busy});
    end

    // glitch: bit1 high for 5 cycles only
    seen_busy = 1'b0;
    sw_raw = 4'h3;
    for (int t = 0; t < 17; t++) begin
      if (t == 5) sw_raw = 4'h1;
      tick();
      seen_busy |= busy;
      chk($sformatf("glitch%0d clean", t), sw_clean, 4'h1);
      chk($sformatf("glitch%0d rise", t), sw_rise, 4'h0);
      chk($sformatf("glitch%0d fall", t), sw_fall, 4'h0);
    end
    chk("glitch busy end", {3'b0, busy}, 4'h0);
    chk("glitch busy seen", {3'b0, seen_busy}, 4'h1);

    // bounce on bit2: four 3-cycle segments, then held high
    for (int p = 0; p < 4; p++) begin
      sw_raw = (p % 2 == 0) ? 4'h5 : 4'h1;
      repeat (3) begin
        tick();
        chk($sformatf("bounce seg%0d clean", p), sw_clean, 4'h1);
        chk($sformatf("bounce seg%0d rise", p), sw_rise, 4'h0);
      end
    end
    sw_raw = 4'h5;
    for (int t = 1; t <= 14; t++) begin
      tick();
      e_clean = (t >= 10) ? 4'h5 : 4'h1;
      e_rise  = (t == 10) ? 4'h4 : 4'h0;
      chk($sformatf("bounce hold%0d clean", t), sw_clean, e_clean);
      chk($sformatf("bounce hold%0d rise", t), sw_rise, e_rise);
      chk($sformatf("bounce hold%0d fall", t), sw_fall, 4'h0);
    end

    // simultaneous multi-bit changes from a fresh reset
    reset_n = 1'b0;
    sw_raw  = 4'h0;
    tick();
    tick();
    reset_n = 1'b1;
    sw_raw  = 4'h5;
    for (int t = 1; t <= 12; t++) begin
      tick();
      e_clean = (t >= 10) ? 4'h5 : 4'h0;
      e_rise  = (t == 10) ? 4'h5 : 4'h0;
      chk($sformatf("sim05 %0d clean", t), sw_clean, e_clean);
      chk($sformatf("sim05 %0d rise", t), sw_rise, e_rise);
      chk($sformatf("sim05 %0d fall", t), sw_fall, 4'h0);
    end
    sw_raw = 4'hA;
    for (int t = 1; t <= 12; t++) begin
      tick();
      e_clean = (t >= 10) ? 4'hA : 4'h5;
      e_rise  = (t == 10) ? 4'hA : 4'h0;
      e_fall  = (t == 10) ? 4'h5 : 4'h0;
      chk($sformatf("sim5A %0d clean", t), sw_clean, e_clean);
      chk($sformatf("sim5A %0d rise", t), sw_rise, e_rise);
      chk($sformatf("sim5A %0d fall", t), sw_fall, e_fall);
    end

    // reset abort while bit3 counter sits at 6
    sw_raw = 4'h0;
    repeat (12) tick();
    chk("abort pre clean", sw_clean, 4'h0);
    sw_raw = 4'h8;
    repeat (8) tick();
    chk("abort pending busy", {3'b0, busy}, 4'h1);
    reset_n = 1'b0;
    #1;
    chk("abort async clean", sw_clean, 4'h0);
    chk("abort async rise", sw_rise, 4'h0);
    chk("abort async fall", sw_fall, 4'h0);
    chk("abort async busy", {3'b0, busy}, 4'h0);
    tick();
    tick();
    chk("abort held busy", {3'b0, busy}, 4'h0);
    reset_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      e_clean = (t >= 10) ? 4'h8 : 4'h0;
      e_rise  = (t == 10) ? 4'h8 : 4'h0;
      e_busy  = (t >= 3 && t <= 9);
      chk($sformatf("abort rel%0d clean", t), sw_clean, e_clean);
      chk($sformatf("abort rel%0d rise", t), sw_rise, e_rise);
      chk($sformatf("abort rel%0d busy", t), {3'b0, busy}, {3'b0, e_busy});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
